// File: rtl/store_buffer.sv
// store_buffer: in-order FIFO of committed stores that sits ahead of the
// data_memory write port. Loads are checked combinationally against it.
// Configuration macro STORE_BUFFER_FWD_EN: when defined, a load fully covered
// by the youngest overlapping store is forwarded from the buffer. When it is
// undefined, any overlap stalls the load until that store drains.
`timescale 1ns/1ps
module store_buffer #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  st_valid_i,
    output logic                  st_ready_o,
    input  logic [ADDR_WIDTH-1:0] st_addr_i,
    input  logic [DATA_WIDTH-1:0] st_data_i,
    input  logic [2:0]            st_funct3_i,
    input  logic                  drain_en_i,
    output logic                  mem_write_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_write_data_o,
    output logic [2:0]            mem_funct3_o,
    input  logic                  ld_valid_i,
    input  logic [ADDR_WIDTH-1:0] ld_addr_i,
    input  logic [2:0]            ld_funct3_i,
    output logic                  ld_hit_o,
    output logic [DATA_WIDTH-1:0] ld_data_o,
    output logic                  ld_stall_o,
    output logic                  empty_o,
    output logic                  full_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0] addr_q   [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_d   [DEPTH];
    logic [DATA_WIDTH-1:0] data_q   [DEPTH];
    logic [DATA_WIDTH-1:0] data_d   [DEPTH];
    logic [2:0]            funct3_q [DEPTH];
    logic [2:0]            funct3_d [DEPTH];
    logic [7:0]            mask_q   [DEPTH];
    logic [7:0]            mask_d   [DEPTH];
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic                  enq;
    logic                  deq;
    logic [7:0]            ld_mask;
    logic                  ld_found;
    logic [PTR_W-1:0]      ld_sel;
    logic [PTR_W-1:0]      scan_idx;

    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        logic [7:0] m;
        case (sz)
            2'd0:    m = 8'h01;
            2'd1:    m = 8'h03;
            2'd2:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    // Acceptance uses the registered count only, so a full buffer never takes
    // a store on the strength of a same-cycle drain.
    assign empty_o          = (count_q == '0);
    assign full_o           = (count_q == CNT_W'(DEPTH));
    assign st_ready_o       = !full_o;
    assign enq              = st_valid_i && st_ready_o;
    assign deq              = !empty_o && drain_en_i;
    assign mem_write_en_o   = deq;
    assign mem_addr_o       = empty_o ? '0 : addr_q[head_q];
    assign mem_write_data_o = empty_o ? '0 : data_q[head_q];
    assign mem_funct3_o     = empty_o ? '0 : funct3_q[head_q];

    // Next-state for pointers, count, valid bits and the entry written at tail.
    always_comb begin
        addr_d   = addr_q;
        data_d   = data_q;
        funct3_d = funct3_q;
        mask_d   = mask_q;
        valid_d  = valid_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        if (deq) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end
        if (enq) begin
            addr_d[tail_q]   = st_addr_i;
            data_d[tail_q]   = st_data_i;
            funct3_d[tail_q] = st_funct3_i;
            mask_d[tail_q]   = size_mask(st_funct3_i[1:0]) << st_addr_i[2:0];
            valid_d[tail_q]  = 1'b1;
            tail_d           = tail_q + 1'b1;
        end
        if (enq && !deq) begin
            count_d = count_q + 1'b1;
        end else if (!enq && deq) begin
            count_d = count_q - 1'b1;
        end
    end

    // Control state; reset discards every buffered store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payload; only meaningful while the matching valid bit is set.
    always_ff @(posedge clk) begin
        addr_q   <= addr_d;
        data_q   <= data_d;
        funct3_q <= funct3_d;
        mask_q   <= mask_d;
    end

    // Scan oldest to youngest so the last overlapping entry found is the youngest.
    // The head entry still takes part while it is being drained.
    always_comb begin
        ld_mask  = size_mask(ld_funct3_i[1:0]) << ld_addr_i[2:0];
        ld_found = 1'b0;
        ld_sel   = '0;
        scan_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_q + PTR_W'(i);
            if (ld_valid_i && valid_q[scan_idx] &&
                (addr_q[scan_idx][ADDR_WIDTH-1:3] == ld_addr_i[ADDR_WIDTH-1:3]) &&
                (|(mask_q[scan_idx] & ld_mask))) begin
                ld_found = 1'b1;
                ld_sel   = scan_idx;
            end
        end
    end

`ifdef STORE_BUFFER_FWD_EN
    logic                  ld_cover;
    logic [DATA_WIDTH-1:0] sel_lane;
    logic [DATA_WIDTH-1:0] ld_shift;
    logic [DATA_WIDTH-1:0] ld_ext;

    // Lane-align the selected store, pull out the load's bytes and extend them.
    always_comb begin
        ld_cover = ((mask_q[ld_sel] & ld_mask) == ld_mask);
        sel_lane = data_q[ld_sel] << {addr_q[ld_sel][2:0], 3'b000};
        ld_shift = sel_lane >> {ld_addr_i[2:0], 3'b000};
        ld_ext   = '0;
        case (ld_funct3_i)
            3'b000:  ld_ext = {{(DATA_WIDTH-8){ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_ext = {{(DATA_WIDTH-16){ld_shift[15]}}, ld_shift[15:0]};
            3'b010:  ld_ext = {{(DATA_WIDTH-32){ld_shift[31]}}, ld_shift[31:0]};
            3'b100:  ld_ext = {{(DATA_WIDTH-8){1'b0}}, ld_shift[7:0]};
            3'b101:  ld_ext = {{(DATA_WIDTH-16){1'b0}}, ld_shift[15:0]};
            3'b110:  ld_ext = {{(DATA_WIDTH-32){1'b0}}, ld_shift[31:0]};
            default: ld_ext = ld_shift;
        endcase
    end

    assign ld_hit_o   = ld_found && ld_cover;
    assign ld_stall_o = ld_found && !ld_cover;
    assign ld_data_o  = ld_hit_o ? ld_ext : '0;
`else
    // Without forwarding only the load size matters, not its signedness.
    logic unused_ld_sign;
    assign unused_ld_sign = ld_funct3_i[2];

    assign ld_hit_o   = 1'b0;
    assign ld_stall_o = ld_found;
    assign ld_data_o  = '0;
`endif

endmodule
